// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high-pulse width in clk cycles with min/max classification; define GLITCH_FILTER_EN for a debounce filter.
module pulse_width_meter #(
  parameter int WIDTH       = 16,
  parameter int MIN_W       = 10,
  parameter int MAX_W       = 500,
  parameter int SYNC_STAGES = 2
`ifdef GLITCH_FILTER_EN
  ,
  parameter int GLITCH_LEN  = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             enable,
  output logic [WIDTH-1:0] width_out,
  output logic             width_valid,
  output logic             too_short,
  output logic             too_long,
  output logic             busy
);
`ifdef GLITCH_FILTER_EN
  localparam int WARM = SYNC_STAGES + GLITCH_LEN + 1;
`else
  localparam int WARM = SYNC_STAGES;
`endif
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_W);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_W);
  typedef enum logic [1:0] {IDLE, MEASURE, OVERRUN} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [WARM-1:0] warm;
  logic [WIDTH-1:0] count;
  logic s, s_d, armed, rise, fall;
  // warm keeps reset-value samples of the pipeline from arming a measurement
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      warm <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse_in};
      warm <= {warm[WARM-2:0], 1'b1};
    end
`ifdef GLITCH_FILTER_EN
  localparam int CW = $clog2(GLITCH_LEN + 1);
  logic [CW-1:0] gcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s    <= 1'b0;
      gcnt <= '0;
    end else if (sync[SYNC_STAGES-1] == s) gcnt <= '0;
    else if (gcnt == CW'(GLITCH_LEN - 1)) begin
      s    <= sync[SYNC_STAGES-1];
      gcnt <= '0;
    end else gcnt <= gcnt + 1'b1;
`else
  assign s = sync[SYNC_STAGES-1];
`endif
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      s_d         <= 1'b0;
      armed       <= 1'b0;
      width_out   <= '0;
      width_valid <= 1'b0;
      too_short   <= 1'b0;
      too_long    <= 1'b0;
    end else begin
      s_d         <= s;
      armed       <= enable & (armed | (~s & warm[WARM-1]));
      width_valid <= 1'b0;
      if (!enable) state <= IDLE;
      else
        case (state)
          IDLE:
            if (rise && armed) begin
              state <= MEASURE;
              count <= WIDTH'(1);
            end
          MEASURE:
            if (fall) begin
              width_out   <= count;
              too_short   <= count < MIN_V;
              too_long    <= count > MAX_V;
              width_valid <= 1'b1;
              state       <= IDLE;
            end else if (s) begin
              count <= count + 1'b1;
              if (&(count + 1'b1)) state <= OVERRUN;
            end
          OVERRUN:
            if (fall) begin
              width_out   <= '1;
              too_short   <= 1'b0;
              too_long    <= 1'b1;
              width_valid <= 1'b1;
              state       <= IDLE;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
Receiver-side counterpart to the team's one-shot pulse generators. It samples an asynchronous pulse line, measures each high pulse in clock cycles and reports the width with a one-cycle valid strobe. It also classifies each pulse against a minimum/maximum window. It sits downstream of monostable/pulse sources and checks their output pulse width.

Parameters:
WIDTH, 16, bit width of the width counter and of width_out
MIN_W, 10, shortest legal pulse in cycles; width < MIN_W flags too_short
MAX_W, 500, longest legal pulse in cycles; width > MAX_W flags too_long
SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2)

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pulse_in  input  1  asynchronous pulse line being measured
enable  input  1  measurement enable; low aborts and idles the block
width_out  output  WIDTH  width of the last completed pulse, in cycles; held until the next report
width_valid  output  1  one-cycle strobe; width_out and the flags are new this cycle
too_short  output  1  last report had width < MIN_W; held with width_out
too_long  output  1  last report had width > MAX_W or saturated; held with width_out
busy  output  1  high while a pulse is being measured (MEASURE or OVERRUN)

Behaviour:
- Reset (async assert, sync release): all outputs 0, counter 0, synchronizer flops 0, state IDLE, armed=0.
- Synchronizer: SYNC_STAGES flops give s. s_d is s delayed one cycle. rise = s & ~s_d; fall = ~s & s_d.
- armed: set in any cycle where s=0 and enable=1; cleared when enable=0. A line already high at reset release or at enable assertion is not measured until it has been seen low.
- States: IDLE, MEASURE, OVERRUN.
- IDLE: rise & armed & enable -> MEASURE, count<=1.
- MEASURE: if s=1, count<=count+1. If count reaches 2^WIDTH-1, go to OVERRUN and hold count.
- MEASURE, fall: width_out<=count; too_short<=(count<MIN_W); too_long<=(count>MAX_W); width_valid=1 for one cycle; go to IDLE.
- OVERRUN, fall: width_out<=all ones; too_long<=1; too_short<=0; width_valid one cycle; go to IDLE.
- Reported width equals the number of cycles s was high. Latency: width_valid rises SYNC_STAGES+1 clocks after pulse_in falls, for a synchronous-looking input.
- A rise in the same cycle as a report cannot occur, because at least one low sample is needed. Back-to-back pulses separated by a 1-cycle low are each reported.
- enable=0 in MEASURE or OVERRUN: abort to IDLE the next cycle. No width_valid. width_out and flags keep their previous values.
- Boundaries: width==MIN_W and width==MAX_W are legal (both flags 0). The range check uses unsigned compare at WIDTH bits.
- busy=1 exactly in MEASURE/OVERRUN.

Optional Feature:
Macro GLITCH_FILTER_EN.
- Defined: a filter follows the synchronizer, with parameter GLITCH_LEN (default 3). The filtered signal changes only after GLITCH_LEN consecutive equal samples of s.
  - Pulses or low gaps shorter than GLITCH_LEN are ignored.
  - Both edges are delayed by GLITCH_LEN cycles, so the reported width of clean pulses is unchanged.
  - Latency grows by GLITCH_LEN.
- Not defined: no filter and no GLITCH_LEN logic. s drives edge detection directly.

Test Plan:
- Reset, enable=1, pulse_in high 10 cycles -> width_valid once, width_out=10, too_short=0, too_long=0, valid SYNC_STAGES+1 clocks after fall.
- Pulses of 9, 500 and 501 cycles -> (9, too_short=1), (500, both flags 0), (501, too_long=1).
- WIDTH=8 override, 300-cycle pulse -> OVERRUN, width_out=255, too_long=1, single valid on fall.
- pulse_in high at reset release for 20 cycles -> no report. A following 12-cycle pulse -> width_out=12.
- enable dropped mid 50-cycle pulse -> no width_valid, busy=0 next cycle, previous width_out held. rst_n asserted mid pulse -> all outputs 0 immediately.
- With GLITCH_FILTER_EN (GLITCH_LEN=3): a 2-cycle spike gives no report. A 40-cycle pulse gives width_out=40, valid 3 cycles later than without the macro.
